// File: rtl/gsim_residual_chk.sv
// gsim_residual_chk: downstream self-check for GSIM.
// Snoops the 16 b samples on the GSIM input bus and captures the 16 x results from GSIM.
// It then emits one residual per row, r[i] = (M*x)[i] - b[i]*2^16, where M is the symmetric
// banded matrix with c(0)=20, c(1)=-13, c(2)=6, c(3)=-1. It also reports max |r| and a pass flag.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   in_en, b_in     - b sample strobe and value (signed 16-bit integer)
//   x_valid, x_in   - x sample strobe and value (signed Q16.16)
//   res_valid       - res_idx/res_out hold a row residual this cycle
//   res_idx,res_out - row index and signed Q16.16 residual
//   done            - frame check complete; max_abs and pass are valid
//   max_abs, pass   - max |r| over the frame, and (max_abs <= TOL)
//   err             - sticky protocol error (extra or out-of-phase samples)
module gsim_residual_chk #(
  parameter int unsigned           RES_W = 40,
  parameter logic [RES_W-1:0]      TOL   = RES_W'(256)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [15:0]      b_in,
  input  logic                    x_valid,
  input  logic signed [31:0]      x_in,
  output logic                    res_valid,
  output logic [3:0]              res_idx,
  output logic signed [RES_W-1:0] res_out,
  output logic                    done,
  output logic [RES_W-1:0]        max_abs,
  output logic                    pass,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t             state;
  logic [4:0]         b_cnt;
  logic [4:0]         x_cnt;
  logic [4:0]         row_cnt;
  logic signed [15:0] b_mem [16];
  logic signed [31:0] x_mem [16];

  logic [3:0]              row;
  logic signed [RES_W-1:0] tv [7];
  logic signed [RES_W-1:0] s1, s2, s3;
  logic signed [RES_W-1:0] sum_c;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] r_c;
  logic [RES_W-1:0]        abs_c;
  logic                    emit_c;
  logic [5:0]              pos;

  assign row = row_cnt[3:0];

  // Seven taps around the current row; out-of-range neighbours contribute zero.
  // pos = row + k - 3 in 6-bit arithmetic, so negative indices wrap to >= 16.
  always_comb begin
    pos = '0;
    for (int k = 0; k < 7; k++) begin
      pos   = 6'(row) + 6'(k) + 6'd61;
      tv[k] = '0;
      if (pos < 6'd16)
        tv[k] = {{(RES_W-32){x_mem[pos[3:0]][31]}}, x_mem[pos[3:0]]};
    end
  end

  // Shift-add coefficient application: 20 = 16+4, 13 = 8+4+1, 6 = 4+2.
  always_comb begin
    s1    = tv[2] + tv[4];
    s2    = tv[1] + tv[5];
    s3    = tv[0] + tv[6];
    sum_c = (tv[3] <<< 4) + (tv[3] <<< 2)
          - ((s1 <<< 3) + (s1 <<< 2) + s1)
          + ((s2 <<< 2) + (s2 <<< 1))
          - s3;
  end

  assign b_ext  = $signed({{(RES_W-32){b_mem[row][15]}}, b_mem[row], 16'h0000});
  assign r_c    = sum_c - b_ext;
  assign abs_c  = r_c[RES_W-1] ? RES_W'(-r_c) : RES_W'(r_c);

  // A row is produced on the first cycle both streams are complete, then once per CALC cycle.
  assign emit_c = ((state == LOAD) && b_cnt[4] && x_cnt[4]) ||
                  ((state == CALC) && !row_cnt[4]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      b_cnt     <= '0;
      x_cnt     <= '0;
      row_cnt   <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_out   <= '0;
      done      <= 1'b0;
      max_abs   <= '0;
      pass      <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (in_en) begin
            if (!b_cnt[4]) begin
              b_mem[b_cnt[3:0]] <= b_in;
              b_cnt             <= b_cnt + 5'd1;
            end else begin
              err <= 1'b1;
            end
          end
          if (x_valid) begin
            if (!x_cnt[4]) begin
              x_mem[x_cnt[3:0]] <= x_in;
              x_cnt             <= x_cnt + 5'd1;
            end else begin
              err <= 1'b1;
            end
          end
          if ((state == IDLE) && (in_en || x_valid))
            state <= LOAD;
          if (emit_c)
            state <= CALC;
        end
        CALC: begin
          if (in_en || x_valid)
            err <= 1'b1;
          if (row_cnt[4]) begin
            done  <= 1'b1;
            pass  <= (max_abs <= TOL);
            state <= DONE;
          end
        end
        DONE: begin
          // A new sample starts the next frame and is stored as element 0.
          if (in_en || x_valid) begin
            state   <= LOAD;
            done    <= 1'b0;
            pass    <= 1'b0;
            max_abs <= '0;
            row_cnt <= '0;
            b_cnt   <= in_en ? 5'd1 : 5'd0;
            x_cnt   <= x_valid ? 5'd1 : 5'd0;
            if (in_en)
              b_mem[0] <= b_in;
            if (x_valid)
              x_mem[0] <= x_in;
          end
        end
        default: state <= IDLE;
      endcase

      if (emit_c) begin
        res_valid <= 1'b1;
        res_idx   <= row;
        res_out   <= r_c;
        row_cnt   <= row_cnt + 5'd1;
        if (abs_c > max_abs)
          max_abs <= abs_c;
      end
    end
  end

endmodule

// File: tb/tb_gsim_residual_chk.sv
// tb_gsim_residual_chk: directed and randomized frames against a matrix-level reference model.
// Ports of the DUT are all driven/observed here; see gsim_residual_chk for their meaning.
module tb_gsim_residual_chk;

  logic               clk;
  logic               reset;
  logic               in_en;
  logic signed [15:0] b_in;
  logic               x_valid;
  logic signed [31:0] x_in;
  logic               res_valid;
  logic [3:0]         res_idx;
  logic signed [39:0] res_out;
  logic               done;
  logic [39:0]        max_abs;
  logic               pass;
  logic               err;

  gsim_residual_chk dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .x_valid(x_valid), .x_in(x_in), .res_valid(res_valid), .res_idx(res_idx),
    .res_out(res_out), .done(done), .max_abs(max_abs), .pass(pass), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] b_q [16];
  logic signed [31:0] x_q [16];
  logic signed [39:0] exp_r [16];
  logic [39:0]        exp_max;
  logic               exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int coef(input int i, input int j);
    int d;
    d = (i > j) ? i - j : j - i;
    case (d)
      0:       return 20;
      1:       return -13;
      2:       return 6;
      3:       return -1;
      default: return 0;
    endcase
  endfunction

  // Reference: full matrix-vector product in 64-bit integers.
  task automatic model();
    longint acc, a;
    exp_max = '0;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int j = 0; j < 16; j++)
        acc += longint'(coef(i, j)) * longint'(x_q[j]);
      acc -= longint'(b_q[i]) * 65536;
      exp_r[i] = 40'(acc);
      a = (acc < 0) ? -acc : acc;
      if (40'(a) > exp_max) exp_max = 40'(a);
    end
  endtask

  task automatic clear_data();
    for (int i = 0; i < 16; i++) begin
      b_q[i] = '0;
      x_q[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: b then x; 1: x first, 3 joint beats, then b; 2: random gaps; 3: as 1 plus a 17th x.
  task automatic feed(input int mode);
    int bi, xi;
    bit sb, sx, started, extra;
    bi = 0; xi = 0; started = 0; extra = 0;
    while (bi < 16 || xi < 16) begin
      sb = 0; sx = 0;
      case (mode)
        0: if (bi < 16) sb = 1; else sx = 1;
        1, 3: begin
          if (xi < 13) sx = 1;
          else if (xi < 16) begin sx = 1; sb = 1; end
          else sb = 1;
        end
        default: begin
          sb = (bi < 16) && ($urandom_range(0, 1) == 1);
          sx = (xi < 16) && ($urandom_range(0, 1) == 1);
        end
      endcase
      in_en   = sb;
      b_in    = sb ? b_q[bi] : 16'sd0;
      x_valid = sx;
      x_in    = sx ? x_q[xi] : 32'sd0;
      if (mode == 3 && xi == 16 && bi == 3 && !extra) begin
        x_valid = 1'b1;
        x_in    = $urandom;
        extra   = 1;
        exp_err = 1'b1;
      end
      if (sb) bi++;
      if (sx) xi++;
      step();
      if (!started && (sb || sx)) begin
        started = 1;
        chk("start_done", 64'(done), 64'(0));
        chk("start_max", 64'(max_abs), 64'(0));
      end
    end
    in_en   = 1'b0;
    x_valid = 1'b0;
  endtask

  // Check 16 result beats and the done cycle; optionally pulse in_en after row poke_row.
  task automatic check_frame(input int poke_row);
    model();
    for (int i = 0; i < 16; i++) begin
      step();
      in_en = 1'b0;
      chk("res_valid", 64'(res_valid), 64'(1));
      chk("res_idx", 64'(res_idx), 64'(i));
      chk("res_out", 64'(res_out), 64'(exp_r[i]));
      chk("done_low", 64'(done), 64'(0));
      if (i == poke_row) begin
        in_en   = 1'b1;
        b_in    = $urandom;
        exp_err = 1'b1;
      end
    end
    step();
    in_en = 1'b0;
    chk("end_valid", 64'(res_valid), 64'(0));
    chk("done", 64'(done), 64'(1));
    chk("max_abs", 64'(max_abs), 64'(exp_max));
    chk("pass", 64'(pass), 64'(exp_max <= 40'd256));
    chk("err", 64'(err), 64'(exp_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_err = 1'b0;
    chk("rst_valid", 64'(res_valid), 64'(0));
    chk("rst_idx", 64'(res_idx), 64'(0));
    chk("rst_out", 64'(res_out), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_max", 64'(max_abs), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) begin
      b_q[i] = $urandom;
      x_q[i] = $urandom;
    end
  endtask

  initial begin
    int kv [16];
    longint acc;
    reset = 1'b0; in_en = 1'b0; x_valid = 1'b0; b_in = '0; x_in = '0; exp_err = 1'b0;
    step();
    do_reset();

    // All zero.
    clear_data();
    feed(0);
    check_frame(-1);

    // Single b.
    clear_data();
    b_q[0] = 16'sh0001;
    feed(0);
    check_frame(-1);

    // Unit x at the top edge.
    clear_data();
    x_q[0] = 32'sh0001_0000;
    feed(2);
    check_frame(-1);

    // Unit x at the bottom edge.
    clear_data();
    x_q[15] = 32'sh0001_0000;
    feed(0);
    check_frame(-1);

    // Interleaved feed with a stray in_en while rows are being emitted.
    rand_data();
    feed(1);
    check_frame(5);

    // Same data fed sequentially after reset must agree; then a 17th x sets err.
    do_reset();
    feed(0);
    check_frame(-1);
    rand_data();
    feed(3);
    check_frame(-1);

    // Reset in the middle of row emission.
    do_reset();
    rand_data();
    feed(0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("part_idx", 64'(res_idx), 64'(i));
    end
    do_reset();

    // Near-solution frame: integer x plus a few LSBs of noise, b = M*x exactly.
    for (int j = 0; j < 16; j++) begin
      kv[j]  = int'($urandom_range(0, 200)) - 100;
      x_q[j] = 32'(kv[j] * 65536 + (int'($urandom_range(0, 6)) - 3));
    end
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int j = 0; j < 16; j++) acc += longint'(coef(i, j) * kv[j]);
      b_q[i] = 16'(acc);
    end
    feed(2);
    check_frame(-1);

    // Full-range random frames.
    for (int n = 0; n < 3; n++) begin
      rand_data();
      feed(2);
      check_frame(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
